// File: rtl/ctrl_pkg.sv
// Shared definitions for the fetch stage and the control unit: fetch FSM
// states, instruction field positions and opcode classes.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    FULL  = 2'd3
  } fetch_state_t;

  // Bit positions of the decoded fields inside a 32-bit instruction word.
  localparam int unsigned COND_MSB  = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_LSB = 20;
  localparam int unsigned RD_LSB    = 12;

  // Opcode classes carried in the op field.
  localparam logic [1:0] OP_DP  = 2'd0;
  localparam logic [1:0] OP_MEM = 2'd1;
  localparam logic [1:0] OP_BR  = 2'd2;

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational split of an instruction word into the fields the
// control unit decodes. Also usable by monitors that disassemble traffic.
module instr_field_split
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd
);

  // Bits outside the decoded fields are intentionally not consumed here.
  logic unused_bits;

  assign cond  = instr[COND_MSB -: 4];
  assign op    = instr[OP_LSB +: 2];
  assign funct = instr[FUNCT_LSB +: 6];
  assign rd    = instr[RD_LSB +: 4];

  assign unused_bits = ^{instr[19:16], instr[11:0]};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and issue stage. Owns the PC, issues one outstanding
// request at a time to instruction memory, holds the returned word for
// decode and applies branch redirects, discarding wrong-path responses.
//
// Decode handshake: dec_valid=1 means the issue register holds an
// instruction; it and all field outputs stay stable until the first cycle
// with dec_valid=1 and dec_ready=1, on which the instruction is consumed at
// the clock edge. dec_valid never drops without that handshake except on a
// branch redirect or reset.
module fetch_unit
  import ctrl_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [31:0]       instr,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        Rd,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] PC_AHEAD = ADDR_W'(8);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_plus8_q, pc_plus8_d;

  // The low target bits are dropped by word alignment.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  // State and datapath registers; reset forgets any outstanding response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= 32'h0;
      pc_plus8_q <= RESET_PC + PC_AHEAD;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      pc_plus8_q <= pc_plus8_d;
    end
  end

  // Next-state logic; a branch overrides dec_ready and imem_valid everywhere.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    pc_plus8_d = pc_plus8_q;

    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // The request to the old pc has already gone out; mark it stale.
        state_d = WAIT;
        if (branch_taken) kill_d = 1'b1;
      end
      WAIT: begin
        if (imem_valid) begin
          // The outstanding request completes either way.
          kill_d = 1'b0;
          if (!kill_q && !branch_taken) begin
            instr_d    = imem_rdata;
            pc_plus8_d = pc_q + PC_AHEAD;
            pc_d       = pc_q + PC_STEP;
            state_d    = FULL;
          end else begin
            state_d = FETCH;
          end
        end else if (branch_taken) begin
          kill_d = 1'b1;
        end
      end
      FULL: begin
        if (branch_taken || dec_ready) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    if (branch_taken) pc_d = {branch_target[ADDR_W-1:2], 2'b00};
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign dec_valid = (state_q == FULL);
  assign instr     = instr_q;
  assign pc_plus8  = pc_plus8_q;
  assign dbg_state = state_q;

  instr_field_split u_split (
    .instr (instr_q),
    .cond  (cond),
    .op    (op),
    .funct (funct),
    .rd    (Rd)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// latency/backpressure traffic scored against a transaction-level model.
module tb_fetch_unit;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        imem_req, imem_valid, branch_taken, dec_ready, dec_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc_plus8;
  logic [3:0]  cond, rd;
  logic [1:0]  op, dbg_state;
  logic [5:0]  funct;

  // Wrap-around instance (RESET_PC = 0xFFFF_FFFC)
  logic        w_imem_req, w_imem_valid, w_branch_taken, w_dec_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_branch_target, w_instr, w_pc_plus8;
  logic [3:0]  w_cond, w_rd;
  logic [1:0]  w_op, w_dbg_state;
  logic [5:0]  w_funct;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .instr(instr),
    .cond(cond), .op(op), .funct(funct), .Rd(rd), .pc_plus8(pc_plus8),
    .dbg_state(dbg_state)
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_valid(w_imem_valid), .imem_rdata(w_imem_rdata),
    .branch_taken(w_branch_taken), .branch_target(w_branch_target),
    .dec_ready(dec_ready), .dec_valid(w_dec_valid), .instr(w_instr),
    .cond(w_cond), .op(w_op), .funct(w_funct), .Rd(w_rd),
    .pc_plus8(w_pc_plus8), .dbg_state(w_dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rel_cyc = 0;

  // Scoreboard: {pc_plus8, instr} of fetches expected to issue, in order.
  logic [63:0] exp_q[$];
  // Model: address the next non-stale fetch must use.
  logic [31:0] exp_addr;

  // Instruction memory contents; address 0 holds 0xE3A01005.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hE3A0_1005;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_valid = 1'b0;
    branch_taken = 1'b0;
    dec_ready = 1'b0;
    w_imem_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    rel_cyc = cyc;
    exp_addr = 32'h0;
    exp_q.delete();
  endtask

  // Wait for the request, answer it after lat cycles and check the issue.
  task automatic fetch_to_full(input int lat, input int exp_wait);
    int n;
    logic [31:0] w;
    logic [63:0] e;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr || n != exp_wait) begin
      miscompares++;
      $display("FAIL fetch_req: req=%b addr=%h wait=%0d, expected req=1 addr=%h wait=%0d",
               imem_req, imem_addr, n, exp_addr, exp_wait);
    end
    w = mem_word(exp_addr);
    exp_q.push_back({exp_addr + 32'd8, w});
    step();
    for (int i = 1; i < lat; i++) step();
    vectors++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_quiet: dec_valid=%b imem_req=%b, expected 0 0", dec_valid, imem_req);
    end
    imem_valid = 1'b1;
    imem_rdata = w;
    step();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    e = exp_q[0];
    vectors++;
    if (dec_valid !== 1'b1 || instr !== e[31:0] || pc_plus8 !== e[63:32] ||
        cond !== e[31:28] || op !== e[27:26] || funct !== e[25:20] || rd !== e[15:12]) begin
      miscompares++;
      $display("FAIL issue: dv=%b instr=%h pc8=%h c=%h o=%h f=%h rd=%h, expected dv=1 instr=%h pc8=%h",
               dec_valid, instr, pc_plus8, cond, op, funct, rd, e[31:0], e[63:32]);
    end
    exp_addr = exp_addr + 32'd4;
  endtask

  // Hold off decode for hold cycles (with stray responses), then accept.
  task automatic accept(input int hold);
    logic [63:0] e;
    e = exp_q[0];
    for (int i = 0; i < hold; i++) begin
      dec_ready = 1'b0;
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      step();
      imem_valid = 1'b0;
      vectors++;
      if (dec_valid !== 1'b1 || instr !== e[31:0] || pc_plus8 !== e[63:32] || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stable: dv=%b instr=%h pc8=%h req=%b, expected dv=1 instr=%h pc8=%h req=0",
                 dec_valid, instr, pc_plus8, imem_req, e[31:0], e[63:32]);
      end
    end
    dec_ready = 1'b1;
    e = exp_q.pop_front();
    step();
    dec_ready = 1'b0;
    vectors++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL refetch: dv=%b req=%b addr=%h, expected dv=0 req=1 addr=%h",
               dec_valid, imem_req, imem_addr, exp_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_valid = 1'b0;
    branch_taken = 1'b0;
    dec_ready = 1'b0;
    w_imem_valid = 1'b0;
    step();
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || dec_valid !== 1'b0 || instr !== 32'h0 ||
        cond !== 4'h0 || op !== 2'h0 || funct !== 6'h0 || rd !== 4'h0 ||
        pc_plus8 !== 32'h8 || dbg_state !== 2'(IDLE)) begin
      miscompares++;
      $display("FAIL reset_values: req=%b addr=%h dv=%b instr=%h pc8=%h st=%0d, expected 0 0 0 0 8 IDLE",
               imem_req, imem_addr, dec_valid, instr, pc_plus8, dbg_state);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_first_fetch: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_basic();
    do_reset();
    dec_ready = 1'b1;
    fetch_to_full(1, 1);
    vectors++;
    if (cyc - rel_cyc != 3 || instr !== 32'hE3A0_1005 || cond !== 4'hE || op !== OP_DP ||
        funct !== 6'h3A || rd !== 4'h1 || pc_plus8 !== 32'h8) begin
      miscompares++;
      $display("FAIL first_issue: cycle=%0d instr=%h c=%h o=%h f=%h rd=%h pc8=%h, expected 3 e3a01005 e 0 3a 1 8",
               cyc - rel_cyc, instr, cond, op, funct, rd, pc_plus8);
    end
    accept(0);
    fetch_to_full(1, 0);
    accept(0);
    fetch_to_full(1, 0);
    accept(0);
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_to_full(2, 1);
    accept(5);
    fetch_to_full(1, 0);
    accept(0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    fetch_to_full(1, 1);
    accept(0);
    for (int k = 0; k < 40; k++) begin
      fetch_to_full($urandom_range(1, 4), 0);
      accept($urandom_range(0, 3));
    end
  endtask

  task automatic test_branch_wait();
    do_reset();
    step();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL bw_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
    step();
    branch_taken = 1'b1;
    branch_target = 32'h103;
    step();
    branch_taken = 1'b0;
    step();
    imem_valid = 1'b1;
    imem_rdata = mem_word(32'h0);
    step();
    imem_valid = 1'b0;
    vectors++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL bw_redirect: dv=%b req=%b addr=%h, expected 0 1 00000100", dec_valid, imem_req, imem_addr);
    end
    exp_addr = 32'h100;
    fetch_to_full(3, 0);
    vectors++;
    if (pc_plus8 !== 32'h108) begin
      miscompares++;
      $display("FAIL bw_pc_plus8: got %h, expected 00000108", pc_plus8);
    end
    accept(0);
  endtask

  task automatic test_branch_coincident();
    logic [31:0] t;
    do_reset();
    fetch_to_full(1, 1);
    accept(0);
    // Branch in the same cycle as the response.
    step();
    t = $urandom;
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    branch_taken = 1'b1;
    branch_target = t;
    step();
    imem_valid = 1'b0;
    branch_taken = 1'b0;
    vectors++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== {t[31:2], 2'b00}) begin
      miscompares++;
      $display("FAIL br_with_valid: dv=%b req=%b addr=%h, expected 0 1 %h",
               dec_valid, imem_req, imem_addr, {t[31:2], 2'b00});
    end
    exp_addr = {t[31:2], 2'b00};
    fetch_to_full(1, 0);
    accept(0);
    // Branch in FULL together with dec_ready.
    fetch_to_full(2, 0);
    t = $urandom;
    dec_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = t;
    step();
    dec_ready = 1'b0;
    branch_taken = 1'b0;
    void'(exp_q.pop_front());
    vectors++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== {t[31:2], 2'b00}) begin
      miscompares++;
      $display("FAIL br_in_full: dv=%b req=%b addr=%h, expected 0 1 %h",
               dec_valid, imem_req, imem_addr, {t[31:2], 2'b00});
    end
    exp_addr = {t[31:2], 2'b00};
    fetch_to_full(1, 0);
    accept(0);
    // Branch in FETCH, then again while the stale request is pending.
    t = $urandom;
    branch_taken = 1'b1;
    branch_target = t;
    step();
    t = $urandom;
    branch_target = t;
    step();
    branch_taken = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    step();
    imem_valid = 1'b0;
    vectors++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== {t[31:2], 2'b00}) begin
      miscompares++;
      $display("FAIL br_in_fetch: dv=%b req=%b addr=%h, expected 0 1 %h",
               dec_valid, imem_req, imem_addr, {t[31:2], 2'b00});
    end
    exp_addr = {t[31:2], 2'b00};
    fetch_to_full(2, 0);
    accept(1);
  endtask

  task automatic test_wrap();
    do_reset();
    vectors++;
    if (w_imem_addr !== 32'hFFFF_FFFC || w_pc_plus8 !== 32'h4 || w_dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_reset: addr=%h pc8=%h dv=%b, expected fffffffc 00000004 0",
               w_imem_addr, w_pc_plus8, w_dec_valid);
    end
    step();
    vectors++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_first_fetch: req=%b addr=%h, expected 1 fffffffc", w_imem_req, w_imem_addr);
    end
    step();
    w_imem_valid = 1'b1;
    w_imem_rdata = mem_word(32'hFFFF_FFFC);
    step();
    w_imem_valid = 1'b0;
    vectors++;
    if (w_dec_valid !== 1'b1 || w_instr !== mem_word(32'hFFFF_FFFC) || w_pc_plus8 !== 32'h4) begin
      miscompares++;
      $display("FAIL wrap_issue: dv=%b instr=%h pc8=%h, expected 1 %h 00000004",
               w_dec_valid, w_instr, w_pc_plus8, mem_word(32'hFFFF_FFFC));
    end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    vectors++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_second_fetch: req=%b addr=%h, expected 1 00000000", w_imem_req, w_imem_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_to_full(1, 1);
    accept(0);
    step();
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (dbg_state !== 2'(IDLE) || imem_req !== 1'b0 || imem_addr !== 32'h0 || dec_valid !== 1'b0 ||
        instr !== 32'h0 || pc_plus8 !== 32'h8) begin
      miscompares++;
      $display("FAIL async_reset: st=%0d req=%b addr=%h dv=%b instr=%h pc8=%h, expected IDLE 0 0 0 0 8",
               dbg_state, imem_req, imem_addr, dec_valid, instr, pc_plus8);
    end
    #1;
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    step();
    imem_valid = 1'b0;
    vectors++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL late_valid_ignored: dv=%b req=%b addr=%h, expected 0 1 00000000",
               dec_valid, imem_req, imem_addr);
    end
    exp_addr = 32'h0;
    exp_q.delete();
    fetch_to_full(1, 0);
    accept(0);
  endtask

  initial begin
    rst = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    dec_ready = 1'b0;
    w_imem_valid = 1'b0;
    w_imem_rdata = 32'h0;
    w_branch_taken = 1'b0;
    w_branch_target = 32'h0;
    exp_addr = 32'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_branch_wait();
    test_branch_coincident();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
